regfile_mp: RTL and testbench

- Parametrised successor of the single-write, dual-read CPU register file. Configurable width, depth and read-port count.
- Adds a zero register, a write-first same-cycle bypass, per-port read enables for pipeline stalls, and a hardware clear sequence on reset.
- Sits in the decode stage. Read data is registered and consumed by ID/EX. Written from the WB stage.
- Uses a single rising clock edge. No negedge write trick.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_bank.sv | 33 +++
 rtl/regfile_mp.sv | 141 ++++++++++++++
 tb/tb_regfile_mp.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_t : top-level sequencing (hardware clear, then normal operation)
//   rd_src_t   : which source drives a read port's registered output
//   MAX_RD     : largest supported number of read ports
//   slice_lo   : low bit index of a port's slice in a packed bus
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYP,
    SRC_RAM
  } rd_src_t;

  localparam int MAX_RD = 4;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline and the register file.
//   rd_en   : per-port read enable (low = hold/stall)
//   rd_addr : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data : packed registered read data, port i at [i*DATA_W +: DATA_W]
//   wr_en, wr_addr, wr_data : single write port from WB
//   ready   : high once the hardware clear has completed
// master = pipeline side, slave = register file side.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, ready
  );

endinterface

// File: rtl/regfile_bank.sv
// One-write / one-read synchronous RAM, DATA_W x DEPTH, with no reset so it
// maps onto block RAM. Read is read-first: a same-address write in the same
// cycle returns the old contents (the caller handles bypass).
//   clk   : clock
//   we, waddr, wdata : write port
//   re, raddr        : read port; rdata only updates when re is high
//   rdata            : registered read data
module regfile_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file for the decode stage.
// After reset it zeroes every entry (one per cycle) before raising ready.
// Each read port owns a RAM bank; all banks take every write so they stay
// coherent. Zero-register, write-first bypass and stall-hold are resolved
// by a small per-port source selector registered alongside the RAM read.
//   clk : clock (posedge only)
//   rst : synchronous active-high reset; restarts the clear sequence
//   bus : regfile_mp_if slave (read ports, write port, ready)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;

  rd_src_t           src_q [NUM_RD];
  rd_src_t           src_d [NUM_RD];
  logic [DATA_W-1:0] byp_q [NUM_RD];
  logic [DATA_W-1:0] byp_d [NUM_RD];

  logic [ADDR_W-1:0] raddr      [NUM_RD];
  logic [DATA_W-1:0] bank_rdata [NUM_RD];

  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic              run;
  logic              wr_to_zero;

  assign run        = (state_q == RUN);
  assign wr_to_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign bus.ready  = ready_q;

  // During CLEAR the shared bank write port is hijacked to zero the entry
  // at clr_ptr; pipeline writes are dropped until RUN.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ready_d    = ready_q;
    bank_we    = 1'b0;
    bank_waddr = bus.wr_addr;
    bank_wdata = bus.wr_data;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          bank_we    = 1'b1;
          bank_waddr = clr_ptr_q;
          bank_wdata = '0;
          clr_ptr_d  = clr_ptr_q + 1'b1;
          if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
        RUN: begin
          bank_we = bus.wr_en && !wr_to_zero;
        end
        default: begin
          state_d = CLEAR;
        end
      endcase
    end
  end

  // Per-port source selection, evaluated only when the port is enabled so a
  // stalled port keeps both its selector and its bank output frozen.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      src_d[i] = src_q[i];
      byp_d[i] = byp_q[i];
      if (!run) begin
        src_d[i] = SRC_ZERO;
      end else if (bus.rd_en[i]) begin
        if ((ZERO_REG != 0) && (raddr[i] == '0)) begin
          src_d[i] = SRC_ZERO;
        end else if (bus.wr_en && (bus.wr_addr == raddr[i])) begin
          src_d[i] = SRC_BYP;
          byp_d[i] = bus.wr_data;
        end else begin
          src_d[i] = SRC_RAM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
        src_q[i] <= SRC_ZERO;
        byp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      for (int i = 0; i < NUM_RD; i++) begin
        src_q[i] <= src_d[i];
        byp_q[i] <= byp_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    assign raddr[g] = bus.rd_addr[slice_lo(g, ADDR_W) +: ADDR_W];

    regfile_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (run && !rst && bus.rd_en[g]),
      .raddr (raddr[g]),
      .rdata (bank_rdata[g])
    );

    // SRC_ZERO also covers reset/clear, so the output is never undefined
    // even though the banks themselves are not reset.
    assign bus.rd_data[slice_lo(g, DATA_W) +: DATA_W] =
      (src_q[g] == SRC_BYP) ? byp_q[g] :
      (src_q[g] == SRC_RAM) ? bank_rdata[g] : '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp. Three instances share clk/rst:
//   u0 : default build (32 x 32, 2 ports, zero register)
//   u1 : same with ZERO_REG = 0
//   u2 : 64-bit x 16, 4 ports, zero register, driven by a reference model
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if1 ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) if2 ();

  regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  regfile_mp #(.DATA_W(64), .DEPTH(16), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  logic [63:0] model [16];
  logic [63:0] expd  [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives the same vector into u0 and u1, then advances one clock.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic e0, input logic [4:0] a0,
                               input logic e1, input logic [4:0] a1);
    if0.wr_en = we; if0.wr_addr = wa; if0.wr_data = wd;
    if0.rd_en = {e1, e0}; if0.rd_addr = {a1, a0};
    if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd;
    if1.rd_en = {e1, e0}; if1.rd_addr = {a1, a0};
    tick();
  endtask

  // Counts posedges (with rst low) until each instance raises ready.
  task automatic waitReady(input string tag, input int exp0, input int exp2);
    int n0 = 0;
    int n1 = 0;
    int n2 = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        checkOutput({tag, "_clr_data0"}, {32'd0, if0.rd_data[31:0]}, 64'd0);
        checkOutput({tag, "_clr_data1"}, {32'd0, if0.rd_data[63:32]}, 64'd0);
      end
      if (n0 == 0 && if0.ready) n0 = n;
      if (n1 == 0 && if1.ready) n1 = n;
      if (n2 == 0 && if2.ready) n2 = n;
    end
    checkOutput({tag, "_ready_u0"}, 64'(n0), 64'(exp0));
    checkOutput({tag, "_ready_u1"}, 64'(n1), 64'(exp0));
    checkOutput({tag, "_ready_u2"}, 64'(n2), 64'(exp2));
  endtask

  initial begin
    if0.wr_en = 0; if0.wr_addr = 0; if0.wr_data = 0; if0.rd_en = 0; if0.rd_addr = 0;
    if1.wr_en = 0; if1.wr_addr = 0; if1.wr_data = 0; if1.rd_en = 0; if1.rd_addr = 0;
    if2.wr_en = 0; if2.wr_addr = 0; if2.wr_data = 0; if2.rd_en = 0; if2.rd_addr = 0;

    $display("[TB] reset and initial clear");
    tick(); tick();
    checkOutput("rst_ready", {63'd0, if0.ready}, 64'd0);
    checkOutput("rst_data",  {32'd0, if0.rd_data[31:0]}, 64'd0);
    rst = 0;
    waitReady("init", 32, 16);

    $display("[TB] basic read/write");
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd5, 1, 5'd5);
    checkOutput("rw_p0",    {32'd0, if0.rd_data[31:0]},  64'hDEADBEEF);
    checkOutput("rw_p1",    {32'd0, if0.rd_data[63:32]}, 64'hDEADBEEF);
    checkOutput("rw_u1_p0", {32'd0, if1.rd_data[31:0]},  64'hDEADBEEF);

    $display("[TB] zero register");
    applyStimulus(1, 5'd0, 32'h12345678, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 5'd0, 1, 5'd0);
    checkOutput("zero_p0",    {32'd0, if0.rd_data[31:0]},  64'h0);
    checkOutput("zero_p1",    {32'd0, if0.rd_data[63:32]}, 64'h0);
    checkOutput("nozero_p0",  {32'd0, if1.rd_data[31:0]},  64'h12345678);
    applyStimulus(1, 5'd0, 32'hCAFEF00D, 1, 5'd0, 0, 0);
    checkOutput("zero_byp_p0",   {32'd0, if0.rd_data[31:0]},  64'h0);
    checkOutput("nozero_byp_p0", {32'd0, if1.rd_data[31:0]},  64'hCAFEF00D);
    checkOutput("nozero_hold_p1", {32'd0, if1.rd_data[63:32]}, 64'h12345678);

    $display("[TB] write-first bypass");
    applyStimulus(1, 5'd7, 32'h00000001, 0, 0, 0, 0);
    applyStimulus(1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 0, 0);
    checkOutput("byp_p0",   {32'd0, if0.rd_data[31:0]},  64'hA5A5A5A5);
    checkOutput("byp_hold", {32'd0, if0.rd_data[63:32]}, 64'h0);
    applyStimulus(0, 0, 0, 1, 5'd7, 1, 5'd7);
    checkOutput("byp_mem_p0", {32'd0, if0.rd_data[31:0]},  64'hA5A5A5A5);
    checkOutput("byp_mem_p1", {32'd0, if0.rd_data[63:32]}, 64'hA5A5A5A5);

    $display("[TB] stall");
    applyStimulus(1, 5'd9, 32'h00000011, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd9);
    checkOutput("stall_pre",  {32'd0, if0.rd_data[63:32]}, 64'h11);
    checkOutput("stall_p0",   {32'd0, if0.rd_data[31:0]},  64'hA5A5A5A5);
    applyStimulus(1, 5'd3, 32'h00000022, 0, 0, 0, 5'd3);
    checkOutput("stall_hold", {32'd0, if0.rd_data[63:32]}, 64'h11);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd3);
    checkOutput("stall_resume", {32'd0, if0.rd_data[63:32]}, 64'h22);

    $display("[TB] reset pulse mid-run");
    rst = 1; tick(); rst = 0;
    checkOutput("pulse_ready", {63'd0, if0.ready}, 64'd0);
    waitReady("pulse", 32, 16);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(0, 0, 0, 1, 5'(a), 1, 5'(31 - a));
      checkOutput($sformatf("cleared_p0_x%0d", a), {32'd0, if0.rd_data[31:0]},  64'h0);
      checkOutput($sformatf("cleared_p1_x%0d", 31 - a), {32'd0, if0.rd_data[63:32]}, 64'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during clear");
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 10; n++) tick();
    checkOutput("midclr_ready", {63'd0, if0.ready}, 64'd0);
    rst = 1; tick(); rst = 0;
    waitReady("restart", 32, 16);

    $display("[TB] 4-port sweep against model");
    for (int a = 0; a < 16; a++) begin
      if2.wr_en = 1; if2.wr_addr = 4'(a);
      if2.wr_data = {32'hA000_0000 + 32'(a), 32'h5000_0000 + 32'(a * 3)};
      model[a] = (a == 0) ? 64'd0 : if2.wr_data;
      tick();
    end
    for (int i = 0; i < 4; i++) expd[i] = 64'd0;
    for (int c = 0; c < 1000; c++) begin
      if2.wr_en   = 1'($urandom_range(0, 1));
      if2.wr_addr = 4'($urandom_range(0, 15));
      if2.wr_data = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        logic [3:0] ra;
        ra = 4'($urandom_range(0, 15));
        if2.rd_en[i] = ($urandom_range(0, 3) != 0);
        if2.rd_addr[i*4 +: 4] = ra;
        if (if2.rd_en[i]) begin
          if (ra == 4'd0) expd[i] = 64'd0;
          else if (if2.wr_en && if2.wr_addr == ra) expd[i] = if2.wr_data;
          else expd[i] = model[ra];
        end
      end
      if (if2.wr_en && if2.wr_addr != 4'd0) model[if2.wr_addr] = if2.wr_data;
      tick();
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("sweep_c%0d_p%0d", c, i), if2.rd_data[i*64 +: 64], expd[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
